// File: rtl/muladd_pkg.sv
// muladd_pkg: shared widths, types and the arithmetic reference for the
// muladd round-robin scheduler.
//   A_W      operand width of the DSP multiplier inputs
//   C_W      addend / result width
//   ID_W     requester-index width held in the tracker (covers up to 8)
//   mac_op_t one requester operation {a, b, c}
//   tag_t    one tracker stage {valid, id}
//   mac_ref  y = a*b + c with signed 8-bit operands, wrapped to 16 bits
package muladd_pkg;

  localparam int A_W  = 8;
  localparam int C_W  = 16;
  localparam int ID_W = 3;

  typedef struct packed {
    logic [A_W-1:0] a;
    logic [A_W-1:0] b;
    logic [C_W-1:0] c;
  } mac_op_t;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  function automatic logic [C_W-1:0] mac_ref(input logic [A_W-1:0] a,
                                             input logic [A_W-1:0] b,
                                             input logic [C_W-1:0] c);
    logic [C_W-1:0] ax;
    logic [C_W-1:0] bx;
    logic [C_W-1:0] prod;
    // Sign-extend both operands; the low 16 bits of the product are the
    // same whether the multiply is treated as signed or unsigned.
    ax   = {{(C_W-A_W){a[A_W-1]}}, a};
    bx   = {{(C_W-A_W){b[A_W-1]}}, b};
    prod = ax * bx;
    return prod + c;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant.
//   req    in  N      pending requests
//   en     in  1      grant permitted this cycle
//   ptr    in  IDX_W  highest-priority index, search proceeds upward with wrap
//   grant  out N      one-hot grant, zero when nothing granted
//   idx    out IDX_W  index of the granted request (0 when none)
//   found  out 1      a grant was issued
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic             en,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        // ptr is always < N, so a single conditional subtract wraps it.
        j = int'(ptr) + k;
        if (j >= N) j = j - N;
        if (!found && req[j]) begin
          found    = 1'b1;
          grant[j] = 1'b1;
          idx      = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/muladd_arbiter.sv
// muladd_arbiter: shares one pipelined multiply-add DSP (y = a*b + c) among
// NREQ requesters with round-robin issue, in-order result routing and a
// whole-pipeline stall when a returning result is not accepted.
//   clock, reset           clock; asynchronous active-low reset
//   req_valid/req_ready    per-requester issue handshake (ready one-hot)
//   req_a/req_b/req_c      per-requester operands, slice i per requester
//   rsp_valid/rsp_ready    per-requester result handshake (valid one-hot)
//   rsp_y                  result data shared by all requesters
//   dsp_a/dsp_b/dsp_c      operands to the DSP
//   dsp_en                 DSP pipeline enable (low while stalled)
//   dsp_y                  DSP result, aligned with the last tracker stage
//   busy                   any operation in flight
module muladd_arbiter
  import muladd_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*A_W-1:0]   req_a,
  input  logic [NREQ*A_W-1:0]   req_b,
  input  logic [NREQ*C_W-1:0]   req_c,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [C_W-1:0]        rsp_y,
  output logic [A_W-1:0]        dsp_a,
  output logic [A_W-1:0]        dsp_b,
  output logic [C_W-1:0]        dsp_c,
  output logic                  dsp_en,
  input  logic [C_W-1:0]        dsp_y,
  output logic                  busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  tag_t             tag_q [LATENCY];
  tag_t             tag_d [LATENCY];
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  mac_op_t          ops [NREQ];
  mac_op_t          sel_op;
  logic [NREQ-1:0]  rsp_hit;
  logic             stall;
  logic             arb_en;
  logic [NREQ-1:0]  grant;
  logic [PTR_W-1:0] gnt_idx;
  logic             gnt_found;

  // Unpack the flat requester buses and decode the last tracker stage.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign ops[gi].a   = req_a[gi*A_W +: A_W];
    assign ops[gi].b   = req_b[gi*A_W +: A_W];
    assign ops[gi].c   = req_c[gi*C_W +: C_W];
    assign rsp_hit[gi] = tag_q[LATENCY-1].valid &&
                         (tag_q[LATENCY-1].id == ID_W'(gi));
  end

  // Only the requester owning the last stage can hold off the pipeline.
  assign stall     = |(rsp_hit & ~rsp_ready);
  assign dsp_en    = ~stall;
  assign rsp_valid = rsp_hit;
  assign rsp_y     = dsp_y;

  // Gating with reset keeps req_ready and the operand mux at their idle
  // values the moment reset asserts, not one edge later.
  assign arb_en = ~stall & reset;

  rr_arbiter #(
    .N     (NREQ),
    .IDX_W (PTR_W)
  ) u_arb (
    .req   (req_valid),
    .en    (arb_en),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (gnt_idx),
    .found (gnt_found)
  );

  assign req_ready = grant;

  always_comb begin
    sel_op = '0;
    if (gnt_found) sel_op = ops[gnt_idx];
  end

  assign dsp_a = sel_op.a;
  assign dsp_b = sel_op.b;
  assign dsp_c = sel_op.c;

  // Tracker and pointer advance together with the DSP; everything holds
  // while stalled so the tag stays aligned with dsp_y.
  always_comb begin
    tag_d = tag_q;
    ptr_d = ptr_q;
    if (!stall) begin
      tag_d[0].valid = gnt_found;
      tag_d[0].id    = ID_W'(gnt_idx);
      for (int i = 1; i < LATENCY; i++) tag_d[i] = tag_q[i-1];
      if (gnt_found) begin
        ptr_d = (gnt_idx == PTR_W'(NREQ-1)) ? '0 : gnt_idx + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
      for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      for (int i = 0; i < LATENCY; i++) tag_q[i] <= tag_d[i];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < LATENCY; i++) busy = busy | tag_q[i].valid;
  end

endmodule

// File: tb/tb_muladd_arbiter.sv
// tb_muladd_arbiter: drives muladd_arbiter with a behavioural DSP model,
// per-requester operation queues and a result scoreboard.
module tb_muladd_arbiter;
  import muladd_pkg::*;

  localparam int NREQ = 4;
  localparam int LAT  = 2;

  typedef struct {
    int          id;
    logic [15:0] y;
    int          cyc;
  } ev_t;

  logic                clock;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*8-1:0]   req_a;
  logic [NREQ*8-1:0]   req_b;
  logic [NREQ*16-1:0]  req_c;
  logic [NREQ-1:0]     rsp_valid;
  logic [NREQ-1:0]     rsp_ready;
  logic [15:0]         rsp_y;
  logic [7:0]          dsp_a;
  logic [7:0]          dsp_b;
  logic [15:0]         dsp_c;
  logic                dsp_en;
  logic [15:0]         dsp_y;
  logic                busy;

  int vectors;
  int miscompares;
  int cyc;

  mac_op_t     pend_q [NREQ][$];
  ev_t         exp_q[$];
  ev_t         obs_q[$];
  ev_t         gnt_q[$];
  logic [NREQ-1:0] rdy_next;

  logic [NREQ-1:0] s_rr;
  logic [NREQ-1:0] s_rv;
  logic [15:0]     s_ry;
  logic            s_en;
  logic            s_busy;

  muladd_arbiter #(.NREQ(NREQ), .LATENCY(LAT)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c     (req_c),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .dsp_a     (dsp_a),
    .dsp_b     (dsp_b),
    .dsp_c     (dsp_c),
    .dsp_en    (dsp_en),
    .dsp_y     (dsp_y),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural DSP: LAT enabled stages from operand capture to dsp_y.
  logic [15:0] dsp_pipe [LAT];
  always @(posedge clock) begin
    if (dsp_en) begin
      dsp_pipe[0] <= mac_ref(dsp_a, dsp_b, dsp_c);
      for (int k = 1; k < LAT; k++) dsp_pipe[k] <= dsp_pipe[k-1];
    end
  end
  assign dsp_y = dsp_pipe[LAT-1];

  // Monitor: record grants/expected results and completed responses.
  always @(negedge clock) begin
    ev_t e;
    if (reset) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.id  = i;
          e.y   = mac_ref(req_a[8*i +: 8], req_b[8*i +: 8], req_c[16*i +: 16]);
          e.cyc = cyc + LAT;
          exp_q.push_back(e);
          e.y   = '0;
          e.cyc = cyc;
          gnt_q.push_back(e);
        end
        if (rsp_valid[i] && rsp_ready[i]) begin
          e.id  = i;
          e.y   = rsp_y;
          e.cyc = cyc;
          obs_q.push_back(e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, act=timeout req=finish");
    $fatal(1);
  end

  task automatic cycle();
    @(posedge clock);
    #1;
    rsp_ready = rdy_next;
    for (int i = 0; i < NREQ; i++) begin
      if (pend_q[i].size() > 0) begin
        req_valid[i]        = 1'b1;
        req_a[8*i +: 8]     = pend_q[i][0].a;
        req_b[8*i +: 8]     = pend_q[i][0].b;
        req_c[16*i +: 16]   = pend_q[i][0].c;
      end else begin
        req_valid[i] = 1'b0;
      end
    end
    @(negedge clock);
    s_rr   = req_ready;
    s_rv   = rsp_valid;
    s_ry   = rsp_y;
    s_en   = dsp_en;
    s_busy = busy;
    for (int i = 0; i < NREQ; i++)
      if (req_valid[i] && req_ready[i]) void'(pend_q[i].pop_front());
  endtask

  task automatic run_until_idle(input int budget, output bit ok);
    bit empty;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      cycle();
      empty = 1'b1;
      for (int i = 0; i < NREQ; i++) if (pend_q[i].size() > 0) empty = 1'b0;
      if (empty && !s_busy && s_rr == '0) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
  endtask

  task automatic clear_queues();
    exp_q.delete();
    obs_q.delete();
    gnt_q.delete();
    for (int i = 0; i < NREQ; i++) pend_q[i].delete();
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    clear_queues();
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    rdy_next  = '1;
    rsp_ready = '1;
    req_valid = '0;
    req_a = '0; req_b = '0; req_c = '0;
    #2;
    reset     = 1'b0;
    req_valid = '1;
    req_a = {NREQ{8'h55}}; req_b = {NREQ{8'h33}}; req_c = {NREQ{16'h1234}};
    #1;
    vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_req_ready act=%b req=0000", req_ready); end
    vectors++; if (rsp_valid !== 4'b0000) begin miscompares++; $display("FAIL reset_rsp_valid act=%b req=0000", rsp_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy act=%b req=0", busy); end
    vectors++; if (dsp_en !== 1'b1) begin miscompares++; $display("FAIL reset_dsp_en act=%b req=1", dsp_en); end
    vectors++; if ({dsp_a, dsp_b, dsp_c} !== 32'h0) begin miscompares++; $display("FAIL reset_dsp_ops act=%h req=0", {dsp_a, dsp_b, dsp_c}); end
    repeat (2) @(posedge clock);
    @(negedge clock);
    req_valid = '0;
    reset = 1'b1;
    clear_queues();
    $display("test_reset done");
  endtask

  task automatic test_single();
    pend_q[0].push_back('{a: 8'd8, b: 8'd2, c: 16'd3});
    cycle();
    vectors++; if (s_rr !== 4'b0001) begin miscompares++; $display("FAIL single_grant act=%b req=0001", s_rr); end
    cycle();
    vectors++; if (s_rv !== 4'b0000) begin miscompares++; $display("FAIL single_early act=%b req=0000", s_rv); end
    cycle();
    vectors++; if (s_rv !== 4'b0001) begin miscompares++; $display("FAIL single_rsp_valid act=%b req=0001", s_rv); end
    vectors++; if (s_ry !== 16'd19) begin miscompares++; $display("FAIL single_rsp_y act=%0d req=19", s_ry); end
    #1;
    clear_queues();
    $display("test_single: 8*2+3 y=%0d", s_ry);
  endtask

  task automatic test_signed();
    bit ok;
    ev_t o, e;
    pend_q[0].push_back('{a: 8'hF8, b: 8'd2, c: 16'd3});
    pend_q[0].push_back('{a: 8'h80, b: 8'h80, c: 16'h8000});
    run_until_idle(40, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL signed_timeout act=busy req=idle"); end
    vectors++; if (obs_q.size() != 2) begin miscompares++; $display("FAIL signed_count act=%0d req=2", obs_q.size()); end
    if (obs_q.size() == 2) begin
      vectors++; if (obs_q[0].y !== 16'hFFF3) begin miscompares++; $display("FAIL signed_neg act=%h req=fff3", obs_q[0].y); end
      vectors++; if (obs_q[1].y !== 16'hC000) begin miscompares++; $display("FAIL signed_wrap act=%h req=c000", obs_q[1].y); end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      vectors++;
      if (o.id !== e.id || o.y !== e.y) begin miscompares++; $display("FAIL signed_sb act=id%0d/%h req=id%0d/%h", o.id, o.y, e.id, e.y); end
      $display("signed: id=%0d y=%h", o.id, o.y);
    end
    clear_queues();
  endtask

  task automatic test_rr();
    bit ok;
    ev_t o, e;
    int  c0;
    mac_op_t op;
    do_reset();
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < NREQ; i++) begin
        op.a = 8'($urandom); op.b = 8'($urandom); op.c = 16'($urandom);
        pend_q[i].push_back(op);
      end
    run_until_idle(60, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rr_timeout act=busy req=idle"); end
    vectors++; if (gnt_q.size() != 12) begin miscompares++; $display("FAIL rr_grants act=%0d req=12", gnt_q.size()); end
    c0 = (gnt_q.size() > 0) ? gnt_q[0].cyc : 0;
    for (int k = 0; k < gnt_q.size(); k++) begin
      vectors++;
      if (gnt_q[k].id != (k % NREQ) || gnt_q[k].cyc != c0 + k) begin
        miscompares++;
        $display("FAIL rr_order k=%0d act=id%0d@%0d req=id%0d@%0d", k, gnt_q[k].id, gnt_q[k].cyc, k % NREQ, c0 + k);
      end
    end
    vectors++; if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL rr_count act=%0d req=%0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      vectors++;
      if (o.id !== e.id || o.y !== e.y || o.cyc != e.cyc) begin
        miscompares++;
        $display("FAIL rr_sb act=id%0d/%h@%0d req=id%0d/%h@%0d", o.id, o.y, o.cyc, e.id, e.y, e.cyc);
      end
      $display("rr: id=%0d y=%h cyc=%0d", o.id, o.y, o.cyc);
    end
    clear_queues();
  endtask

  task automatic test_stall();
    bit ok, seen;
    ev_t o, e;
    logic [15:0] held;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pend_q[i].push_back('{a: 8'(i + 3), b: 8'hFD, c: 16'(100 * i)});
      pend_q[i].push_back('{a: 8'(i + 9), b: 8'd7, c: 16'hF000});
    end
    rdy_next = 4'b1101;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      cycle();
      if (s_rv[1]) seen = 1'b1;
    end
    vectors++; if (!seen) begin miscompares++; $display("FAIL stall_reach act=none req=rsp_valid[1]"); end
    held = s_ry;
    for (int n = 0; n < 5; n++) begin
      cycle();
      vectors++;
      if (s_en !== 1'b0 || s_rr !== 4'b0000 || s_rv !== 4'b0010 || s_ry !== held) begin
        miscompares++;
        $display("FAIL stall_hold n=%0d act=en%b/rr%b/rv%b/%h req=en0/rr0000/rv0010/%h", n, s_en, s_rr, s_rv, s_ry, held);
      end
    end
    rdy_next = '1;
    run_until_idle(60, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL stall_timeout act=busy req=idle"); end
    vectors++; if (obs_q.size() != 6 || exp_q.size() != 6) begin miscompares++; $display("FAIL stall_count act=%0d/%0d req=6/6", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      vectors++;
      if (o.id !== e.id || o.y !== e.y) begin miscompares++; $display("FAIL stall_sb act=id%0d/%h req=id%0d/%h", o.id, o.y, e.id, e.y); end
      $display("stall: id=%0d y=%h", o.id, o.y);
    end
    clear_queues();
  endtask

  task automatic test_sparse();
    bit ok;
    ev_t o, e;
    int  want [4] = '{3, 1, 3, 1};
    do_reset();
    pend_q[1].push_back('{a: 8'd1, b: 8'd1, c: 16'd0});
    run_until_idle(20, ok);
    clear_queues();
    for (int r = 0; r < 2; r++) begin
      pend_q[1].push_back('{a: 8'(r + 2), b: 8'h90, c: 16'h0101});
      pend_q[3].push_back('{a: 8'h7F, b: 8'(r + 5), c: 16'hFFFF});
    end
    run_until_idle(40, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL sparse_timeout act=busy req=idle"); end
    vectors++; if (gnt_q.size() != 4) begin miscompares++; $display("FAIL sparse_grants act=%0d req=4", gnt_q.size()); end
    for (int k = 0; k < gnt_q.size() && k < 4; k++) begin
      vectors++;
      if (gnt_q[k].id != want[k]) begin miscompares++; $display("FAIL sparse_order k=%0d act=%0d req=%0d", k, gnt_q[k].id, want[k]); end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      vectors++;
      if (o.id !== e.id || o.y !== e.y) begin miscompares++; $display("FAIL sparse_sb act=id%0d/%h req=id%0d/%h", o.id, o.y, e.id, e.y); end
      $display("sparse: id=%0d y=%h", o.id, o.y);
    end
    clear_queues();
  endtask

  task automatic test_reset_mid();
    do_reset();
    pend_q[0].push_back('{a: 8'd3, b: 8'd4, c: 16'd5});
    pend_q[1].push_back('{a: 8'd6, b: 8'd7, c: 16'd8});
    cycle();
    cycle();
    cycle();
    vectors++; if (s_busy !== 1'b1 || s_rv !== 4'b0001) begin miscompares++; $display("FAIL mid_inflight act=busy%b/rv%b req=busy1/rv0001", s_busy, s_rv); end
    reset = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 4'b0000 || rsp_valid !== 4'b0000 || busy !== 1'b0 || dsp_en !== 1'b1 ||
        {dsp_a, dsp_b, dsp_c} !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_reset_outs act=rr%b/rv%b/busy%b/en%b req=rr0000/rv0000/busy0/en1", req_ready, rsp_valid, busy, dsp_en);
    end
    clear_queues();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int n = 0; n < 4; n++) begin
      cycle();
      vectors++; if (s_rv !== 4'b0000 || s_busy !== 1'b0) begin miscompares++; $display("FAIL mid_stale n=%0d act=rv%b/busy%b req=0000/0", n, s_rv, s_busy); end
    end
    pend_q[2].push_back('{a: 8'd8, b: 8'd2, c: 16'd3});
    cycle();
    vectors++; if (s_rr !== 4'b0100) begin miscompares++; $display("FAIL mid_grant act=%b req=0100", s_rr); end
    cycle();
    cycle();
    vectors++; if (s_rv !== 4'b0100 || s_ry !== 16'd19) begin miscompares++; $display("FAIL mid_rsp act=%b/%0d req=0100/19", s_rv, s_ry); end
    #1;
    clear_queues();
    $display("test_reset_mid: post-reset y=%0d", s_ry);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    test_reset();
    test_single();
    test_signed();
    test_rr();
    test_stall();
    test_sparse();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muladd_arbiter.md
# muladd_arbiter

Round-robin scheduler that shares one pipelined fused multiply-add DSP (`y = a*b + c`, signed 8-bit operands, 16-bit addend and result) among `NREQ` requesters. Sits between the requester ports and the `main` muladd datapath. Issues at most one operation per cycle, tags each in-flight operation with its requester index, and routes the result back to that requester. Stalls the whole DSP pipeline through its `en` input when a returning result is not accepted.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `LATENCY`, 2: DSP cycles from an enabled operand capture to a valid `dsp_y` (1..4).

Ports:
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  requester i has an operation pending.
- `req_ready`  out  NREQ  one-hot or zero; operation i accepted this cycle.
- `req_a`  in  NREQ*8  per-requester signed multiplicand; slice i = bits [8i+7:8i].
- `req_b`  in  NREQ*8  per-requester signed multiplier.
- `req_c`  in  NREQ*16  per-requester addend.
- `rsp_valid`  out  NREQ  one-hot or zero; result for requester i on `rsp_y`.
- `rsp_ready`  in  NREQ  requester i accepts its result.
- `rsp_y`  out  16  result data, shared by all requesters.
- `dsp_a`, `dsp_b`  out  8  operands to DSP.
- `dsp_c`  out  16  addend to DSP.
- `dsp_en`  out  1  DSP pipeline enable.
- `dsp_y`  in  16  DSP result.
- `busy`  out  1  any operation in flight.

## Operation
- Tracker: `LATENCY`-deep shift register of {valid, id}; stage 0 is loaded with the accepted operation, stage `LATENCY-1` aligns with `dsp_y`. Shifts only when `dsp_en`=1.
- `stall` = last stage valid AND `rsp_ready[id]`=0. `dsp_en` = NOT `stall`.
- `rsp_valid[id]` = last-stage valid; `rsp_y` = `dsp_y`, passed through combinationally. A result completes when `rsp_valid[i]` and `rsp_ready[i]` are both 1.
- Arbitration when `stall`=0: grant the first requester with `req_valid` set, searching from pointer `ptr` upward with wrap. `req_ready[g]`=1. Mux slice g onto `dsp_a`/`dsp_b`/`dsp_c`. Stage 0 loads {1,g}. `ptr` <= (g+1) mod NREQ.
- No valid request, or `stall`=1: `req_ready`=0 and `ptr` holds. With no request, stage 0 loads a bubble {0,x}.
- While `stall`=1, the DSP holds its operands, so `dsp_a`/`dsp_b`/`dsp_c` value is don't-care.
- Arithmetic is performed by the DSP: sign-extend a and b, take the 16-bit product, add c, wrap modulo 2^16. Bench reference is `$signed(a)*$signed(b)+c` truncated to 16 bits.
- `busy` = OR of all tracker valid bits.

## Timing
- Reset (asynchronous assert, clock-synchronous release): tracker valid bits 0, `ptr`=0. Outputs: `req_ready`=0, `rsp_valid`=0, `busy`=0, `dsp_en`=1, `dsp_a`/`dsp_b`/`dsp_c`=0.
- Issue-to-response latency is exactly `LATENCY` enabled cycles. Request accepted at edge k means `rsp_valid` high in cycle k+`LATENCY` with no stall.
- Throughput: one operation per cycle while `rsp_ready` is held high.
- Stall: pipeline, tracker, `ptr` and the responding `rsp_valid`/`rsp_y` all hold until `rsp_ready[id]` rises. In that cycle the result completes, and a new request can be accepted in the same cycle.
- Simultaneous events: a response to requester i and a new grant to i in the same cycle are legal.
- Reset mid-operation discards all in-flight operations; no `rsp_valid` follows.
- `req_valid` must stay high with stable data until `req_ready`. `rsp_valid` is never withdrawn before it completes.

## Structure
- Package `muladd_pkg` holds:
  - `A_W`=8 and `C_W`=16
  - type `mac_op_t` {a, b, c}
  - type `tag_t` {valid, id}
  - function `mac_ref` (reference result for benches)
- Sub-module `rr_arbiter` (parameter `N`) takes request, enable and pointer, and returns a one-hot grant and its index. The tracker and muxing stay in the top.

## Test plan
- Single request, requester 0: a=8, b=2, c=3 -> `req_ready[0]` in cycle 0; `rsp_valid[0]`=1 with `rsp_y`=19 exactly 2 cycles later.
- Signed ops: a=-8, b=2, c=3 -> -13 (0xFFF3). a=-128, b=-128, c=0x8000 -> 0xC000 (wrap).
- All 4 requesters valid continuously, `rsp_ready` all 1 -> grants 0,1,2,3,0,… one per cycle. Each result is routed to the correct `rsp_valid` bit, 2 cycles after its grant.
- Hold `rsp_ready[1]`=0 for 5 cycles while its result is at the last stage -> `dsp_en`=0 and `req_ready`=0 throughout, `rsp_y` stable. On release the results resume in order with no loss or duplication.
- Only requesters 1 and 3 valid, `ptr`=2 -> grant order 3,1,3,1.
- Assert `reset` low with 2 operations in flight -> all outputs take reset values immediately. After release no stale `rsp_valid`, and the first new request returns after 2 cycles.
